// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, error codes, and command and reply bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_NOACK    = 2'b10;
    localparam logic [1:0] ERR_BUSYLINE = 2'b11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ECHO    = 8'hEE;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    localparam int unsigned CNT_W = 21;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for PS2_CLK/PS2_DATA plus a registered PS2_CLK falling-edge pulse.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fe
);

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic clk_fe_q, clk_fe_d;

    always_comb begin
        clk_meta_d  = ps2_clk_in;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data_in;
        data_sync_d = data_meta_q;
        clk_prev_d  = clk_sync_q;
        clk_fe_d    = clk_prev_q & ~clk_sync_q;
    end

    // Line flops reset to the idle (pulled-up) level so reset release cannot fake an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_prev_q  <= 1'b1;
            clk_fe_q    <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            clk_fe_q    <= clk_fe_d;
        end
    end

    assign clk_sync  = clk_sync_q;
    assign data_sync = data_sync_q;
    assign clk_fe    = clk_fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check,
// and a bus-idle wait, driving the open-drain lines through output enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES   = 12000,
    parameter int unsigned TIMEOUT_CYCLES   = 1500000,
    parameter int unsigned IDLE_WAIT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LIM     = CNT_W'(IDLE_WAIT_CYCLES);

    logic clk_sync, data_sync, clk_fe;

    ps2_line_sync u_line_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fe      (clk_fe)
    );

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [3:0]       bit_n_q, bit_n_d;
    logic [8:0]       shift_q, shift_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] tmo_inc, idle_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        bit_n_d    = bit_n_q;
        shift_d    = shift_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
        tmo_inc    = tmo_q + 1'b1;
        idle_inc   = (clk_sync && data_sync) ? cnt_q + 1'b1 : '0;

        // The done/err cycle is the last busy cycle, so tx_ready rises one cycle after the pulse.
        if (done_q || err_q) begin
            state_d   = IDLE;
            cnt_d     = '0;
            tmo_d     = '0;
            bit_n_d   = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_d   = {odd_parity(tx_data), tx_data};
                        cnt_d     = '0;
                        tmo_d     = '0;
                        bit_n_d   = '0;
                        clk_oe_d  = 1'b1;
                        data_oe_d = 1'b0;
                        state_d   = INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (data_oe_q) begin
                        clk_oe_d = 1'b0;
                        tmo_d    = '0;
                        bit_n_d  = '0;
                        state_d  = SEND;
                    end else if (cnt_q >= INHIBIT_LAST) begin
                        data_oe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                SEND: begin
                    if (clk_fe) begin
                        tmo_d = '0;
                        if (bit_n_q >= 4'd9) begin
                            data_oe_d = 1'b0;
                            state_d   = ACK;
                        end else begin
                            data_oe_d = ~shift_q[0];
                            shift_d   = {1'b0, shift_q[8:1]};
                            bit_n_d   = bit_n_q + 1'b1;
                        end
                    end else if (tmo_inc >= TIMEOUT_LIM) begin
                        clk_oe_d   = 1'b0;
                        data_oe_d  = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                ACK: begin
                    if (clk_fe) begin
                        tmo_d = '0;
                        if (!data_sync) begin
                            cnt_d   = '0;
                            state_d = WAIT_IDLE;
                        end else begin
                            clk_oe_d   = 1'b0;
                            data_oe_d  = 1'b0;
                            err_d      = 1'b1;
                            err_code_d = ERR_NOACK;
                        end
                    end else if (tmo_inc >= TIMEOUT_LIM) begin
                        clk_oe_d   = 1'b0;
                        data_oe_d  = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
                WAIT_IDLE: begin
                    if (idle_inc >= IDLE_LIM) begin
                        done_d = 1'b1;
                    end else if (tmo_inc >= TIMEOUT_LIM) begin
                        clk_oe_d   = 1'b0;
                        data_oe_d  = 1'b0;
                        err_d      = 1'b1;
                        err_code_d = ERR_BUSYLINE;
                    end else begin
                        cnt_d = idle_inc;
                        tmo_d = tmo_inc;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            bit_n_q    <= '0;
            shift_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            bit_n_q    <= bit_n_d;
            shift_q    <= shift_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign rx_inhibit  = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule
